// File: rtl/alu_issue_stage.sv
// ALU issue stage: request FIFO feeding a combinational ALU, with a registered
// result slot, overflow sticky flag and capture counter.
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [2:0]  in_op,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_res,
  input  logic        alu_co,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [2:0]  out_flags,
  output logic        ovf_sticky,
  input  logic        clr_sticky,
  output logic [15:0] op_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends combinationally on ready from the same side.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   mem_a  [DEPTH];
  logic [31:0]   mem_b  [DEPTH];
  logic [2:0]    mem_op [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic empty;
  logic push;
  logic capture;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The head is captured only once it was visible before the edge, so a push
  // into an empty FIFO always spends one cycle at the head.
  assign capture  = !empty && (!out_valid || out_ready);

  assign alu_A   = empty ? 32'h0 : mem_a[rd_ptr];
  assign alu_B   = empty ? 32'h0 : mem_b[rd_ptr];
  assign alu_ctr = empty ? 3'b000 : mem_op[rd_ptr];

  // Storage needs no reset: validity is carried entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= in_a;
      mem_b[wr_ptr]  <= in_b;
      mem_op[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (capture) rd_ptr <= rd_ptr + AW'(1);
      case ({push, capture})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_res    <= 32'h0;
      out_flags  <= 3'b000;
      ovf_sticky <= 1'b0;
      op_count   <= 16'h0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_res   <= alu_res;
        out_flags <= {alu_overflow, alu_zero, alu_co};
        op_count  <= op_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A new overflow outranks a clear arriving on the same edge.
      if (capture && alu_overflow) ovf_sticky <= 1'b1;
      else if (clr_sticky)         ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: bench-side ALU model, scoreboard queue fed by an
// input monitor and drained by an output monitor, plus directed scenarios.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_res;
  logic        alu_co;
  logic        alu_zero;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_flags;
  logic        ovf_sticky;
  logic        clr_sticky;
  logic [15:0] op_count;

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  logic [34:0] exp_q[$];
  int          pop_cycles[$];
  logic [15:0] acc_cnt  = 16'h0;
  logic        sticky_m = 1'b0;

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctr(alu_ctr),
    .alu_res(alu_res), .alu_co(alu_co), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flags(out_flags),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .op_count(op_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- ALU model: {ovf, zero, co, res} ----------------
  function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        co, ov;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                  ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; co = (a < b);
                  ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a >> b[4:0];
      3'd6: r = a << b[4:0];
      default: r = {31'h0, $signed(a) < $signed(b)};
    endcase
    return {ov, (r == 32'h0), co, r};
  endfunction

  assign {alu_overflow, alu_zero, alu_co, alu_res} = alu_f(alu_A, alu_B, alu_ctr);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input monitor: a request accepted at the coming edge enters the scoreboard.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      logic [34:0] e;
      e = alu_f(in_a, in_b, in_op);
      exp_q.push_back(e);
      acc_cnt  = acc_cnt + 16'd1;
      sticky_m = sticky_m | e[34];
    end
  end

  // Output monitor: compares each consumed result and checks hold under stall.
  logic        held_v = 1'b0;
  logic [31:0] held_res;
  logic [2:0]  held_flags;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        check("hold_res", out_res, held_res);
        check("hold_flags", {29'h0, out_flags}, {29'h0, held_flags});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_result: got %h expected none", out_res);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("out_res", out_res, e[31:0]);
          check("out_flags", {29'h0, out_flags}, {29'h0, e[34:32]});
          pop_cycles.push_back(cyc);
        end
      end
      held_v     = out_valid && !out_ready;
      held_res   = out_res;
      held_flags = out_flags;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit got;
    got = 0;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_total++;
      n_bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      n_total++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    cycles(2);
  endtask

  function automatic logic [31:0] rnd_a();
    return ($urandom_range(0, 3) == 0) ? 32'h7fffffff : $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_op = '0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;

    #3;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_res", out_res, 32'h0);
    check("rst_op_count", {16'h0, op_count}, 32'h0);
    check("rst_alu_A", alu_A, 32'h0);
    check("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // single op with one-cycle latency
    out_ready = 1'b1;
    push(32'h00001000, 32'h2, 3'b101);
    check("lat_not_same_edge", {31'h0, out_valid}, 32'h0);
    check("lat_head_A", alu_A, 32'h00001000);
    cycles(1);
    check("lat_out_valid", {31'h0, out_valid}, 32'h1);
    check("lat_out_res", out_res, 32'h00000400);
    check("lat_op_count", {16'h0, op_count}, 32'h1);
    drain();

    // randomized traffic with random backpressure
    begin
      bit took;
      for (int i = 0; i < 400; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid || took) begin
          in_valid = $urandom_range(0, 1);
          in_a = rnd_a();
          in_b = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom;
          in_op = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        took = in_valid && in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
    end
    drain();
    check("rand_op_count", {16'h0, op_count}, {16'h0, acc_cnt});
    check("rand_sticky", {31'h0, ovf_sticky}, {31'h0, sticky_m});

    // backpressure: FIFO fills, 6th request blocked until downstream ready
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h100 + i, 32'h1, 3'd0);
    in_a = 32'h555; in_b = 32'h1; in_op = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    push(32'h555, 32'h1, 3'd0);
    drain();

    // streaming: back-to-back pushes, one result per cycle
    pop_cycles.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) push($urandom, $urandom, 3'($urandom_range(0, 7)));
    check("stream_push_cycles", cyc - c0, 32'd8);
    drain();
    check("stream_results", pop_cycles.size(), 32'd8);
    if (pop_cycles.size() == 8)
      check("stream_consecutive", pop_cycles[7] - pop_cycles[0], 32'd7);

    // sticky overflow: set wins over same-edge clear
    clr_sticky = 1'b1;
    cycles(1);
    clr_sticky = 1'b0;
    check("sticky_cleared", {31'h0, ovf_sticky}, 32'h0);
    push(32'h7fffffff, 32'h1, 3'd0);
    clr_sticky = 1'b1;
    cycles(1);
    clr_sticky = 1'b0;
    check("sticky_set_wins", {31'h0, ovf_sticky}, 32'h1);
    check("sticky_flag", {31'h0, out_flags[2]}, 32'h1);
    drain();
    clr_sticky = 1'b1;
    cycles(1);
    clr_sticky = 1'b0;
    sticky_m = 1'b0;
    check("sticky_clear_alone", {31'h0, ovf_sticky}, 32'h0);

    // reset mid-stream with queued entries and a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h900 + i, 32'h3, 3'd3);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    acc_cnt = 16'h0;
    sticky_m = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_op_count", {16'h0, op_count}, 32'h0);
    check("mid_rst_alu_A", alu_A, 32'h0);
    check("mid_rst_out_res", out_res, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(10);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("post_rst_op_count", {16'h0, op_count}, 32'h0);

    // op_count wrap after 65536 captures
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) push($urandom, $urandom, 3'($urandom_range(0, 7)));
    drain();
    check("wrap_model", {16'h0, op_count}, {16'h0, acc_cnt});
    check("wrap_zero", {16'h0, op_count}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
